// File: rtl/fu_completion_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// completion_pkg
// Shared types and default sizing for the FU completion arbiter slice.
//   DEFAULT_INST_ID_BITS : default width of an instruction ID
//   DEFAULT_FU_COUNT     : default number of functional units
//   DEFAULT_FIFO_DEPTH   : default entries per per-FU completion FIFO
//   idx_width()          : index width helper that never returns zero
// -----------------------------------------------------------------------------
package completion_pkg;

    localparam int DEFAULT_INST_ID_BITS = 6;
    localparam int DEFAULT_FU_COUNT     = 4;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef logic [DEFAULT_INST_ID_BITS-1:0]      inst_id_t;
    typedef logic [$clog2(DEFAULT_FU_COUNT)-1:0]  fu_idx_t;

    typedef struct packed {
        inst_id_t id;
    } completion_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fu_completion_arbiter_if.sv
// -----------------------------------------------------------------------------
// fu_completion_arbiter_if
// Bundles the FU-side completion inputs/readies and the ROB completion port.
//   master : environment side (FU wrappers + ROB) driving completions/flush/ready
//   slave  : arbiter side
// Signals:
//   fu_out_valid / fu_out_inst_id : per-FU completion pulse and ID
//   fu_ready                      : per-FU back-pressure (FIFO not full)
//   flush                         : discard all buffered completions
//   rob_complete_valid/_inst_id/_fu/_ready : ROB completion handshake
// -----------------------------------------------------------------------------
interface fu_completion_arbiter_if
    import completion_pkg::*;
#(
    parameter int INST_ID_BITS = DEFAULT_INST_ID_BITS,
    parameter int FU_COUNT     = DEFAULT_FU_COUNT
);
    localparam int FU_IDX_W = idx_width(FU_COUNT);

    logic [FU_COUNT-1:0]                   fu_out_valid;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_out_inst_id;
    logic [FU_COUNT-1:0]                   fu_ready;
    logic                                  flush;
    logic                                  rob_complete_valid;
    logic [INST_ID_BITS-1:0]               rob_complete_inst_id;
    logic [FU_IDX_W-1:0]                   rob_complete_fu;
    logic                                  rob_complete_ready;

    modport master (
        output fu_out_valid, fu_out_inst_id, flush, rob_complete_ready,
        input  fu_ready, rob_complete_valid, rob_complete_inst_id, rob_complete_fu
    );

    modport slave (
        input  fu_out_valid, fu_out_inst_id, flush, rob_complete_ready,
        output fu_ready, rob_complete_valid, rob_complete_inst_id, rob_complete_fu
    );

endinterface

// File: rtl/fu_completion_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// completion_fifo
// Single-FU completion FIFO. Same-cycle push and pop both take effect.
// A pop on an empty FIFO is ignored. flush empties it at the next edge.
// Ports:
//   clk, rst (async, active-low), flush
//   push, push_data : write one entry (caller guarantees !full)
//   pop             : drop the head entry
//   full, empty     : from the registered count
//   head            : oldest entry
// -----------------------------------------------------------------------------
module completion_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fu_completion_arbiter.sv
// -----------------------------------------------------------------------------
// fu_completion_arbiter
// Buffers per-FU completion pulses in one FIFO per FU and merges them
// round-robin onto the single ROB completion port (valid/ready).
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : fu_completion_arbiter_if.slave (FU completions, fu_ready, flush,
//          ROB completion handshake)
// Optional (macro FU_COMPLETION_STATS_EN):
//   stall_cycles[i]          : cycles with fu_ready[i]==0 (saturating)
//   rob_backpressure_cycles  : cycles with valid && !ready (saturating)
// -----------------------------------------------------------------------------
module fu_completion_arbiter
    import completion_pkg::*;
#(
    parameter int INST_ID_BITS = DEFAULT_INST_ID_BITS,
    parameter int FU_COUNT     = DEFAULT_FU_COUNT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    fu_completion_arbiter_if.slave     bus
`ifdef FU_COMPLETION_STATS_EN
    ,
    output logic [FU_COUNT-1:0][31:0]  stall_cycles,
    output logic [31:0]                rob_backpressure_cycles
`endif
);
    localparam int FU_IDX_W = idx_width(FU_COUNT);

    logic [FU_COUNT-1:0]                   full;
    logic [FU_COUNT-1:0]                   empty;
    logic [FU_COUNT-1:0]                   push;
    logic [FU_COUNT-1:0]                   pop;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0] head;

    logic [FU_IDX_W-1:0] rr_ptr;
    logic                lock;
    logic [FU_IDX_W-1:0] locked_grant;
    logic [FU_IDX_W-1:0] rr_grant;
    logic [FU_IDX_W-1:0] grant;
    logic [FU_IDX_W-1:0] grant_next;
    logic                valid;
    logic                handshake;

    assign bus.fu_ready = ~full;

    for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
        // Pushes in a flush cycle are dropped along with the buffered entries.
        assign push[g] = bus.fu_out_valid[g] && !full[g] && !bus.flush;
        assign pop[g]  = handshake && (grant == FU_IDX_W'(g));

        completion_fifo #(
            .WIDTH (INST_ID_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .push      (push[g]),
            .push_data (bus.fu_out_inst_id[g]),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (head[g])
        );

        a_no_push_when_full: assert property (
            @(posedge clk) disable iff (!rst) !(bus.fu_out_valid[g] && full[g]));
    end

    // First non-empty FIFO scanning upward from rr_ptr with wrap.
    always_comb begin
        logic                found;
        logic [FU_IDX_W-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        rr_grant = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            idx = FU_IDX_W'((int'(rr_ptr) + i) % FU_COUNT);
            if (!found && !empty[idx]) begin
                found    = 1'b1;
                rr_grant = idx;
            end
        end
    end

    // A locked grant always points at a non-empty FIFO: only a handshake pops
    // it, and a handshake or flush clears the lock.
    assign grant      = lock ? locked_grant : rr_grant;
    assign valid      = !(&empty) && !bus.flush;
    assign handshake  = valid && bus.rob_complete_ready;
    assign grant_next = (grant == FU_IDX_W'(FU_COUNT - 1)) ? '0 : grant + 1'b1;

    assign bus.rob_complete_valid   = valid;
    assign bus.rob_complete_inst_id = valid ? head[grant] : '0;
    assign bus.rob_complete_fu      = valid ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            lock         <= 1'b0;
            locked_grant <= '0;
        end else if (bus.flush) begin
            rr_ptr       <= '0;
            lock         <= 1'b0;
        end else if (handshake) begin
            rr_ptr       <= grant_next;
            lock         <= 1'b0;
        end else if (valid) begin
            lock         <= 1'b1;
            locked_grant <= grant;
        end
    end

`ifdef FU_COMPLETION_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles            <= '0;
            rob_backpressure_cycles <= '0;
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                if (full[i] && (stall_cycles[i] != '1)) begin
                    stall_cycles[i] <= stall_cycles[i] + 1'b1;
                end
            end
            if (valid && !bus.rob_complete_ready && (rob_backpressure_cycles != '1)) begin
                rob_backpressure_cycles <= rob_backpressure_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_completion_arbiter.sv
module tb_fu_completion_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    fu_completion_arbiter_if #(.INST_ID_BITS(6), .FU_COUNT(4)) bus ();

`ifdef FU_COMPLETION_STATS_EN
    logic [3:0][31:0] stall_cycles;
    logic [31:0]      rob_backpressure_cycles;
`endif

    fu_completion_arbiter #(
        .INST_ID_BITS (6),
        .FU_COUNT     (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FU_COMPLETION_STATS_EN
        ,
        .stall_cycles            (stall_cycles),
        .rob_backpressure_cycles (rob_backpressure_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [5:0] id, input logic [1:0] fu);
        chk({tag, "_valid"}, 32'(bus.rob_complete_valid), 32'(v));
        chk({tag, "_id"},    32'(bus.rob_complete_inst_id), 32'(id));
        chk({tag, "_fu"},    32'(bus.rob_complete_fu), 32'(fu));
    endtask

    task automatic idle_in();
        bus.fu_out_valid   = '0;
        bus.fu_out_inst_id = '0;
        bus.flush          = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0;
        idle_in();
        bus.rob_complete_ready = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fu_ready", 32'(bus.fu_ready), 32'hF);
        chk_out("rst", 1'b0, 6'd0, 2'd0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("idle_fu_ready", 32'(bus.fu_ready), 32'hF);
        chk_out("idle", 1'b0, 6'd0, 2'd0);

        // Single completion, no bypass
        bus.rob_complete_ready = 1'b1;
        bus.fu_out_valid = 4'b0100;
        bus.fu_out_inst_id[2] = 6'd5;
        #1;
        chk("no_bypass", 32'(bus.rob_complete_valid), 32'd0);
        cyc();
        idle_in();
        #1;
        chk_out("single", 1'b1, 6'd5, 2'd2);
        cyc();
        chk("single_drain", 32'(bus.rob_complete_valid), 32'd0);

        // rr_ptr is now 3: FU3 wins over FU0
        bus.fu_out_valid = 4'b1001;
        bus.fu_out_inst_id[0] = 6'd30;
        bus.fu_out_inst_id[3] = 6'd33;
        cyc();
        idle_in();
        #1;
        chk_out("rr3_a", 1'b1, 6'd33, 2'd3);
        cyc();
        chk_out("rr3_b", 1'b1, 6'd30, 2'd0);
        cyc();
        chk("rr3_drain", 32'(bus.rob_complete_valid), 32'd0);

        // Empty flush returns rr_ptr to 0
        bus.flush = 1'b1;
        cyc();
        idle_in();

        // Round-robin over all four FUs
        bus.fu_out_valid = 4'b1111;
        for (int i = 0; i < 4; i++) bus.fu_out_inst_id[i] = 6'(10 + i);
        cyc();
        idle_in();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("rr4_%0d", i), 1'b1, 6'(10 + i), 2'(i));
            cyc();
        end
        chk("rr4_drain", 32'(bus.rob_complete_valid), 32'd0);
        bus.fu_out_valid = 4'b0011;
        bus.fu_out_inst_id[0] = 6'd20;
        bus.fu_out_inst_id[1] = 6'd21;
        cyc();
        idle_in();
        #1;
        chk_out("wrap_a", 1'b1, 6'd20, 2'd0);
        cyc();
        chk_out("wrap_b", 1'b1, 6'd21, 2'd1);
        cyc();
        chk("wrap_drain", 32'(bus.rob_complete_valid), 32'd0);

        // Backpressure and lock (rr_ptr=2, so FU0 would win without lock)
        bus.rob_complete_ready = 1'b0;
        bus.fu_out_valid = 4'b0010;
        bus.fu_out_inst_id[1] = 6'd7;
        cyc();
        idle_in();
        #1;
        chk_out("lock_a", 1'b1, 6'd7, 2'd1);
        bus.fu_out_valid = 4'b0001;
        bus.fu_out_inst_id[0] = 6'd3;
        cyc();
        idle_in();
        #1;
        chk_out("lock_b", 1'b1, 6'd7, 2'd1);
        cyc();
        chk_out("lock_c", 1'b1, 6'd7, 2'd1);
        bus.rob_complete_ready = 1'b1;
        cyc();
        chk_out("lock_after", 1'b1, 6'd3, 2'd0);
        cyc();
        chk("lock_drain", 32'(bus.rob_complete_valid), 32'd0);

        // Full FIFO on FU3
        bus.rob_complete_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            bus.fu_out_valid = 4'b1000;
            bus.fu_out_inst_id[3] = 6'(v);
            cyc();
            chk($sformatf("full_rdy_%0d", v), 32'(bus.fu_ready[3]), 32'(v < 4));
        end
        idle_in();
        #1;
        chk("full_vec", 32'(bus.fu_ready), 32'h7);
        chk_out("full_head", 1'b1, 6'd1, 2'd3);
        bus.rob_complete_ready = 1'b1;
        cyc();
        bus.rob_complete_ready = 1'b0;
        #1;
        chk("unfull_vec", 32'(bus.fu_ready), 32'hF);
        chk_out("order_2", 1'b1, 6'd2, 2'd3);
        bus.rob_complete_ready = 1'b1;
        cyc();
        chk_out("order_3", 1'b1, 6'd3, 2'd3);
        cyc();
        chk_out("order_4", 1'b1, 6'd4, 2'd3);
        cyc();
        chk("full_drain", 32'(bus.rob_complete_valid), 32'd0);

        // Flush with a same-cycle push
        bus.rob_complete_ready = 1'b0;
        bus.fu_out_valid = 4'b0111;
        bus.fu_out_inst_id[0] = 6'd40;
        bus.fu_out_inst_id[1] = 6'd41;
        bus.fu_out_inst_id[2] = 6'd42;
        cyc();
        idle_in();
        cyc();
        chk("pre_flush_valid", 32'(bus.rob_complete_valid), 32'd1);
        bus.flush = 1'b1;
        bus.fu_out_valid = 4'b0001;
        bus.fu_out_inst_id[0] = 6'd9;
        #1;
        chk("flush_valid", 32'(bus.rob_complete_valid), 32'd0);
        cyc();
        idle_in();
        #1;
        chk_out("post_flush", 1'b0, 6'd0, 2'd0);
        chk("post_flush_rdy", 32'(bus.fu_ready), 32'hF);
        bus.rob_complete_ready = 1'b1;
        cyc();
        chk("flush_no_9", 32'(bus.rob_complete_valid), 32'd0);

        // Asynchronous reset mid-operation
        bus.rob_complete_ready = 1'b0;
        bus.fu_out_valid = 4'b0010;
        bus.fu_out_inst_id[1] = 6'd17;
        cyc();
        idle_in();
        #1;
        chk_out("pre_rst", 1'b1, 6'd17, 2'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 6'd0, 2'd0);
        rst = 1'b1;
        cyc();
        chk("rst_lost", 32'(bus.rob_complete_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
